// File: rtl/access_decision_ctrl.sv
// access_decision_ctrl
//   Sequences the CNN inference pipeline for the access-control door:
//   requests frames, collects classifier results, votes over consecutive
//   authorised ids and drives a timed door-open output.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   start        begin an attempt (honoured only when idle)
//   cancel       abort attempt / close door, highest priority below reset
//   id_in        classifier id, qualified by id_valid
//   id_valid     one-cycle qualifier for id_in
//   frame_req    one-cycle pulse requesting a new frame
//   busy         high whenever not idle
//   door_open    high exactly while the door is held open
//   grant        one-cycle pulse on entering the open state
//   deny         one-cycle pulse when the frame budget runs out
//   timeout_err  one-cycle pulse when a frame result never arrives
//   result_id    last accepted id
//   vote_cnt     current consecutive-vote count
module access_decision_ctrl #(
  parameter int unsigned        ID_W           = 3,
  parameter int unsigned        VOTE_N         = 3,
  parameter int unsigned        MAX_FRAMES     = 8,
  parameter int unsigned        TIMEOUT_CYCLES = 2000000,
  parameter int unsigned        OPEN_CYCLES    = 50000000,
  parameter logic [2**ID_W-1:0] AUTH_MASK      = 8'b0000_0110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cancel,
  input  logic [ID_W-1:0] id_in,
  input  logic            id_valid,
  output logic            frame_req,
  output logic            busy,
  output logic            door_open,
  output logic            grant,
  output logic            deny,
  output logic            timeout_err,
  output logic [ID_W-1:0] result_id,
  output logic [3:0]      vote_cnt
);

  localparam int unsigned TIMER_MAX = (TIMEOUT_CYCLES > OPEN_CYCLES) ? TIMEOUT_CYCLES : OPEN_CYCLES;
  localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam int unsigned FRAME_W   = 8;
  localparam int unsigned VOTE_W    = 4;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OPEN_LAST    = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LIMIT  = FRAME_W'(MAX_FRAMES);
  localparam logic [VOTE_W-1:0]  VOTE_TARGET  = VOTE_W'(VOTE_N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EVAL = 3'd3,
    S_OPEN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [VOTE_W-1:0]  vote_d;
  logic [VOTE_W-1:0]  vote_inc;
  logic [ID_W-1:0]    voted_id_q, voted_id_d;
  logic [ID_W-1:0]    result_id_d;
  logic               id_auth;
  logic               grant_d, deny_d, timeout_d;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      frame_q     <= '0;
      voted_id_q  <= '0;
      vote_cnt    <= '0;
      result_id   <= '0;
      frame_req   <= 1'b0;
      busy        <= 1'b0;
      door_open   <= 1'b0;
      grant       <= 1'b0;
      deny        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_q     <= frame_d;
      voted_id_q  <= voted_id_d;
      vote_cnt    <= vote_d;
      result_id   <= result_id_d;
      // Level outputs follow the state being entered so they align with it
      frame_req   <= (state_d == S_REQ);
      busy        <= (state_d != S_IDLE);
      door_open   <= (state_d == S_OPEN);
      grant       <= grant_d;
      deny        <= deny_d;
      timeout_err <= timeout_d;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_d     = frame_q;
    vote_d      = vote_cnt;
    voted_id_d  = voted_id_q;
    result_id_d = result_id;
    grant_d     = 1'b0;
    deny_d      = 1'b0;
    timeout_d   = 1'b0;
    id_auth     = AUTH_MASK[result_id];
    vote_inc    = (vote_cnt >= VOTE_TARGET) ? vote_cnt : vote_cnt + VOTE_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          vote_d  = '0;
          frame_d = '0;
        end
      end

      S_REQ: begin
        frame_d = frame_q + FRAME_W'(1);
        timer_d = '0;
        state_d = S_WAIT;
      end

      // A result arriving on the last timer cycle still wins over the timeout
      S_WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (id_valid) begin
          result_id_d = id_in;
          state_d     = S_EVAL;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          vote_d    = '0;
          timer_d   = '0;
          state_d   = S_IDLE;
        end
      end

      S_EVAL: begin
        if (!id_auth) begin
          vote_d = '0;
        end else if ((vote_cnt == '0) || (result_id == voted_id_q)) begin
          vote_d     = vote_inc;
          voted_id_d = result_id;
        end else begin
          vote_d     = VOTE_W'(1);
          voted_id_d = result_id;
        end

        if (vote_d == VOTE_TARGET) begin
          grant_d = 1'b1;
          timer_d = '0;
          state_d = S_OPEN;
        end else if (frame_q == FRAME_LIMIT) begin
          deny_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_OPEN: begin
        if (timer_q == OPEN_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides everything and suppresses any pulse this cycle
    if (cancel) begin
      state_d     = S_IDLE;
      vote_d      = '0;
      timer_d     = '0;
      frame_d     = '0;
      result_id_d = result_id;
      grant_d     = 1'b0;
      deny_d      = 1'b0;
      timeout_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_access_decision_ctrl.sv
// Self-checking bench for access_decision_ctrl: directed attempts from the
// test plan followed by randomized attempts checked against a vote model.
module tb_access_decision_ctrl;

  localparam int unsigned ID_W     = 3;
  localparam int unsigned VOTE_N   = 3;
  localparam int unsigned MAX_FR   = 5;
  localparam int unsigned TIMEOUT  = 100;
  localparam int unsigned OPEN     = 20;
  localparam logic [7:0]  AUTH     = 8'b0000_0110;

  logic            clk = 1'b0;
  logic            rst_n, start, cancel, id_valid;
  logic [ID_W-1:0] id_in;
  logic            frame_req, busy, door_open, grant, deny, timeout_err;
  logic [ID_W-1:0] result_id;
  logic [3:0]      vote_cnt;

  access_decision_ctrl #(
    .ID_W(ID_W), .VOTE_N(VOTE_N), .MAX_FRAMES(MAX_FR),
    .TIMEOUT_CYCLES(TIMEOUT), .OPEN_CYCLES(OPEN), .AUTH_MASK(AUTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .id_in(id_in), .id_valid(id_valid),
    .frame_req(frame_req), .busy(busy), .door_open(door_open),
    .grant(grant), .deny(deny), .timeout_err(timeout_err),
    .result_id(result_id), .vote_cnt(vote_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int fr_cnt = 0, gr_cnt = 0, dn_cnt = 0, to_cnt = 0, do_cnt = 0;
  int rsp_id [16];
  int rsp_dly[16];
  logic [ID_W-1:0] last_rid;

  // Pulse/level counters sampled mid-cycle
  always @(negedge clk) begin
    if (frame_req === 1'b1)   fr_cnt++;
    if (grant === 1'b1)       gr_cnt++;
    if (deny === 1'b1)        dn_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
    if (door_open === 1'b1)   do_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rsp(input int idx, input int id, input int dly);
    rsp_id[idx]  = id;
    rsp_dly[idx] = dly;
  endtask

  // Runs one attempt of up to n frames, predicting votes and outcome from the
  // voting rules. cancel_at >= 0 cancels that many cycles into the open period;
  // rst_frame >= 0 pulses reset while waiting on that frame.
  task automatic do_attempt(input int n, input int cancel_at, input int rst_frame);
    int mv, mlast, cnt;
    int f0, g0, d0, t0, o0;
    int ef, eg, ed, et, eo;
    f0 = fr_cnt; g0 = gr_cnt; d0 = dn_cnt; t0 = to_cnt; o0 = do_cnt;
    ef = 0; eg = 0; ed = 0; et = 0; eo = 0;
    mv = 0; mlast = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("frame_req", 32'(frame_req), 32'd1);
      ef++;
      step();
      if (i == rst_frame) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
        last_rid = '0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vote", 32'(vote_cnt), 32'd0);
        check("rst_rid", 32'(result_id), 32'd0);
        break;
      end
      if (rsp_dly[i] >= int'(TIMEOUT)) begin
        repeat (TIMEOUT - 1) step();
        check("timeout_early", 32'(timeout_err), 32'd0);
        step();
        check("timeout_pulse", 32'(timeout_err), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_vote", 32'(vote_cnt), 32'd0);
        et++;
        break;
      end
      repeat (rsp_dly[i]) step();
      id_in = ID_W'(rsp_id[i]); id_valid = 1'b1;
      step();
      id_valid = 1'b0; id_in = ID_W'($urandom);
      last_rid = ID_W'(rsp_id[i]);
      check("result_id", 32'(result_id), 32'(last_rid));
      if (AUTH[rsp_id[i]]) begin
        if (mv == 0 || rsp_id[i] == mlast) mv = (mv < int'(VOTE_N)) ? mv + 1 : mv;
        else mv = 1;
        mlast = rsp_id[i];
      end else begin
        mv = 0;
      end
      step();
      check("vote_cnt", 32'(vote_cnt), 32'(mv));
      if (mv == int'(VOTE_N)) begin
        check("grant_pulse", 32'(grant), 32'd1);
        eg++;
        cnt = 0;
        while (door_open === 1'b1 && cnt < 4 * int'(OPEN)) begin
          if (cnt == cancel_at) cancel = 1'b1;
          step();
          cancel = 1'b0;
          cnt++;
        end
        eo = (cancel_at >= 0) ? cancel_at + 1 : int'(OPEN);
        check("door_cycles", 32'(cnt), 32'(eo));
        check("open_done_busy", 32'(busy), 32'd0);
        break;
      end else if (i + 1 == int'(MAX_FR)) begin
        check("deny_pulse", 32'(deny), 32'd1);
        check("deny_busy", 32'(busy), 32'd0);
        ed++;
        break;
      end
    end
    repeat (3) step();
    check("n_frame_req", 32'(fr_cnt - f0), 32'(ef));
    check("n_grant", 32'(gr_cnt - g0), 32'(eg));
    check("n_deny", 32'(dn_cnt - d0), 32'(ed));
    check("n_timeout", 32'(to_cnt - t0), 32'(et));
    check("n_door", 32'(do_cnt - o0), 32'(eo));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int f0, g0, d0, t0, o0, r;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; id_valid = 1'b0; id_in = '0;
    last_rid = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_door", 32'(door_open), 32'd0);
    check("reset_frame_req", 32'(frame_req), 32'd0);
    check("reset_pulses", 32'({grant, deny, timeout_err}), 32'd0);
    check("reset_rid", 32'(result_id), 32'd0);
    check("reset_vote", 32'(vote_cnt), 32'd0);

    // id_valid while idle is ignored
    id_in = 3'd7; id_valid = 1'b1; step(); id_valid = 1'b0; step();
    check("idle_id_ignored", 32'(result_id), 32'd0);
    check("idle_stays", 32'(busy), 32'd0);

    // 1: three matching authorised ids
    for (int i = 0; i < 3; i++) set_rsp(i, 1, 10);
    do_attempt(3, -1, -1);

    // 2: switch id resets the streak to 1
    set_rsp(0, 1, 10); set_rsp(1, 2, 10); set_rsp(2, 2, 10); set_rsp(3, 2, 10);
    do_attempt(4, -1, -1);
    check("t2_result_id", 32'(result_id), 32'd2);

    // 3: unauthorised ids exhaust the budget
    set_rsp(0, 0, 4); set_rsp(1, 3, 4); set_rsp(2, 0, 4); set_rsp(3, 5, 4); set_rsp(4, 0, 4);
    do_attempt(5, -1, -1);

    // 4: timeout, then result on the final timer cycle
    set_rsp(0, 1, int'(TIMEOUT));
    do_attempt(1, -1, -1);
    set_rsp(0, 1, int'(TIMEOUT) - 1); set_rsp(1, 1, 3); set_rsp(2, 1, 3);
    do_attempt(3, -1, -1);

    // 5a: cancel while open
    for (int i = 0; i < 3; i++) set_rsp(i, 2, 2);
    do_attempt(3, 5, -1);

    // 5b: cancel while waiting, then a late result
    f0 = fr_cnt; g0 = gr_cnt; d0 = dn_cnt; t0 = to_cnt; o0 = do_cnt;
    start = 1'b1; step(); start = 1'b0;
    check("c_frame_req", 32'(frame_req), 32'd1);
    repeat (4) step();
    cancel = 1'b1; step(); cancel = 1'b0;
    check("c_busy", 32'(busy), 32'd0);
    repeat (2) step();
    id_in = 3'd5; id_valid = 1'b1; step(); id_valid = 1'b0;
    check("c_late_rid", 32'(result_id), 32'(last_rid));
    step();
    check("c_vote", 32'(vote_cnt), 32'd0);
    check("c_idle", 32'(busy), 32'd0);
    check("c_pulses", 32'((gr_cnt - g0) + (dn_cnt - d0) + (to_cnt - t0) + (do_cnt - o0)), 32'd0);
    check("c_frames", 32'(fr_cnt - f0), 32'd1);

    // 6: reset mid-wait with two votes banked, then a fresh attempt
    for (int i = 0; i < 3; i++) set_rsp(i, 1, 5);
    do_attempt(3, -1, 2);
    id_in = 3'd1; id_valid = 1'b1; step(); id_valid = 1'b0; step();
    check("r_late_rid", 32'(result_id), 32'd0);
    do_attempt(3, -1, -1);

    // Randomized attempts, mostly authorised ids to reach grants
    for (int a = 0; a < 30; a++) begin
      for (int i = 0; i < int'(MAX_FR); i++) begin
        r = int'($urandom_range(0, 3));
        rsp_id[i]  = (r == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 2));
        rsp_dly[i] = ($urandom_range(0, 19) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, 12));
      end
      do_attempt(int'(MAX_FR), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
